// File: rtl/data_mem_responder.sv
// Byte-addressed, big-endian data memory that serves one access at a time, with a fixed LATENCY.
// Define MEM_ALIGN_CHECK_EN to reject accesses whose address is not a multiple of xfer_size.
module data_mem_responder #(
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] address,
    input  logic        write_enable,
    input  logic        read_enable,
    input  logic [3:0]  xfer_size,
    input  logic [63:0] write_data,
    output logic [63:0] read_data,
    output logic        mem_stall,
    output logic        mem_ready,
    output logic        mem_error,
    output logic [1:0]  dbg_state_o
);
    localparam int AW = $clog2(DEPTH_BYTES);

    // Handshake: a request (read_enable XOR write_enable) is accepted on any IDLE cycle.
    // mem_stall stays high from the request cycle until DONE. DONE lasts one cycle and
    // carries exactly one pulse, mem_ready or mem_error.
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [AW-1:0]  addr_q;
    logic [3:0]     size_q;
    logic [63:0]    wdata_q;
    logic           wr_q;
    logic           err_q;
    logic [63:0]    rdata_q;
    logic           ready_q;
    logic           error_q;
    logic [7:0]     mem_q [DEPTH_BYTES];

    logic           request;
    logic           accept;
    logic           finish;
    logic           size_ok;
    logic           range_ok;
    logic           align_ok;
    logic           legal;
    logic [64:0]    end_addr;
    logic [63:0]    wleft;
    logic [63:0]    rd_word;

    assign request = read_enable ^ write_enable;

    // The range check uses a 65-bit sum, so an address near 2^64 cannot wrap into range.
    always_comb begin
        size_ok  = (xfer_size == 4'd1) || (xfer_size == 4'd2) ||
                   (xfer_size == 4'd4) || (xfer_size == 4'd8);
        end_addr = {1'b0, address} + {61'd0, xfer_size};
        range_ok = end_addr <= 65'(DEPTH_BYTES);
`ifdef MEM_ALIGN_CHECK_EN
        align_ok = (address[3:0] & (xfer_size - 4'd1)) == 4'd0;
`else
        align_ok = 1'b1;
`endif
        legal    = size_ok && range_ok && align_ok;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (request) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                    cnt_d   = 4'(LATENCY - 1);
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 64'd0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= finish && !err_q;
            error_q <= finish && err_q;
            if (finish && !wr_q && !err_q) begin
                rdata_q <= rd_word;
            end
        end
    end

    // Request fields are captured once at acceptance; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (reset && accept) begin
            addr_q  <= address[AW-1:0];
            size_q  <= xfer_size;
            wdata_q <= write_data;
            wr_q    <= write_enable;
            err_q   <= !legal;
        end
    end

    // Left-justify the store data so byte i of the transfer is always wleft[63-8i -: 8].
    always_comb begin
        wleft   = wdata_q << (7'd64 - {size_q, 3'b000});
        rd_word = 64'd0;
        for (int i = 0; i < 8; i++) begin
            if (i < int'(size_q)) begin
                rd_word = {rd_word[55:0], mem_q[addr_q + AW'(i)]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset && finish && wr_q && !err_q) begin
            for (int i = 0; i < 8; i++) begin
                if (i < int'(size_q)) begin
                    mem_q[addr_q + AW'(i)] <= wleft[63-8*i -: 8];
                end
            end
        end
    end

    assign mem_stall   = reset && (((state_q == IDLE) && request) || (state_q == BUSY));
    assign mem_ready   = ready_q;
    assign mem_error   = error_q;
    assign read_data   = rdata_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter: DEPTH_BYTES, default 1024, memory size in bytes (power of two, at least 64).
REQ-002 Parameter: LATENCY, default 2, busy cycles per access (1..15).
REQ-003 Port: clk, input, 1, the only clock; all state changes on posedge clk.
REQ-004 Port: reset, input, 1, synchronous active-low reset; asserted when 0 and sampled only on posedge clk.
REQ-005 Port: address, input, 64, byte address of the access.
REQ-006 Port: write_enable, input, 1, store request.
REQ-007 Port: read_enable, input, 1, load request.
REQ-008 Port: xfer_size, input, 4, access width in bytes; legal values are 1, 2, 4 and 8.
REQ-009 Port: write_data, input, 64, store data, right-justified.
REQ-010 Port: read_data, output, 64, load data, right-justified and zero-extended.
REQ-011 Port: mem_stall, output, 1, holds the requester's pipeline.
REQ-012 Port: mem_ready, output, 1, one-cycle pulse marking access completion.
REQ-013 Port: mem_error, output, 1, one-cycle pulse marking a rejected access.

Function
REQ-014 The block SHALL use the states IDLE, BUSY and DONE.
REQ-015 In IDLE, a request is read_enable XOR write_enable; at posedge the block SHALL latch address, xfer_size, write_data and direction, load cnt=LATENCY-1 and go to BUSY.
REQ-016 In BUSY, the block SHALL decrement cnt each cycle and go to DONE when cnt==0.
REQ-017 In DONE, the block SHALL go to IDLE on the next posedge, regardless of inputs.
REQ-018 mem_stall SHALL be combinational: (IDLE and request) or BUSY; it SHALL be low in DONE.
REQ-019 A legal access SHALL complete LATENCY+1 cycles after acceptance.
REQ-020 Input changes after acceptance SHALL be ignored; only latched values are used.
REQ-021 Byte order is big-endian: the byte at the lowest address is the most-significant byte of the transfer.
REQ-022 A write SHALL commit to the array only on the BUSY->DONE edge.
REQ-023 A read SHALL sample the array on the BUSY->DONE edge; read_data is registered and SHALL hold its value until the next completed read.
REQ-024 mem_ready SHALL be high exactly during DONE for a legal access.
REQ-025 An access SHALL be illegal if xfer_size is not in {1,2,4,8} or address+xfer_size > DEPTH_BYTES.
REQ-026 An illegal access SHALL perform no array change and leave read_data unchanged.
REQ-027 For an illegal access, mem_error SHALL replace mem_ready during DONE, with the same timing.
REQ-028 When read_enable and write_enable are both high in IDLE, the block SHALL do nothing: stay in IDLE, keep mem_stall low and raise no pulse.
REQ-029 Address arithmetic SHALL be 64-bit; no wrap-around at DEPTH_BYTES is permitted, so an overflowing access is illegal.

Reset
REQ-030 On posedge clk with reset==0, the block SHALL set state=IDLE, cnt=0, read_data=0, mem_ready=0 and mem_error=0.
REQ-031 mem_stall SHALL be 0 while reset is asserted.
REQ-032 Reset during BUSY SHALL abort the access with no array write.
REQ-033 The memory array is not cleared by reset; its contents are undefined at power-up.

Configuration
REQ-034 With MEM_ALIGN_CHECK_EN defined, an access whose address is not a multiple of xfer_size SHALL be illegal (mem_error, no array effect).
REQ-035 Without MEM_ALIGN_CHECK_EN, misaligned accesses SHALL be performed byte-wise at address..address+xfer_size-1.

Verification
REQ-036 Write: write_enable, address=0, xfer_size=8, write_data=64'h0102030405060708, LATENCY=2 -> mem_stall high for 3 cycles, mem_ready pulses in cycle 4, array bytes [0]=01 through [7]=08.
REQ-037 Read: byte access at address=3 after REQ-036 -> read_data=64'h04 on mem_ready; a following 4-byte access at address=4 -> 64'h05060708.
REQ-038 Both enables high -> no stall, no pulse, array and read_data unchanged.
REQ-039 8-byte access at address=DEPTH_BYTES-4 -> mem_error pulse and no write; 8-byte access at address=4 -> mem_error if MEM_ALIGN_CHECK_EN is defined, otherwise mem_ready and bytes 4..11 written.
REQ-040 reset=0 in the first BUSY cycle of a write to address 16 -> IDLE next cycle, outputs 0, array byte 16 unchanged; next request accepted normally.
